button_event: RTL and testbench

- Consumes the debounced button level from the debounce stage.
- Classifies activity into one-cycle event pulses: press, release, click, double-click, long press and auto-repeat.
- Sits between the debounce stage and the user logic, such as counters or mode selectors, so that logic never times raw levels itself.
- All timing derives from a 1 ms prescaler locked to button edges.

---
 rtl/button_event.sv | 196 +++++++++++++++++++
 tb/tb_button_event.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_event.sv
// -----------------------------------------------------------------------------
// button_event
//
// Turns a debounced push-button level into one-cycle event pulses so that
// downstream user logic (counters, mode selectors) never times raw levels.
// All timing is derived from a 1 ms prescaler that restarts on every button
// edge and on every state entry, so each threshold lands exactly
// N*DIV cycles after the pulse that opened its interval.
//
// Parameters
//   CLOCK_RATE_HZ  system clock frequency; multiple of 1000, >= 1000
//   LONG_MS        hold time (ms) that turns a press into a long press, >= 1
//   REPEAT_MS      auto-repeat period (ms) while held after o_long, >= 1
//   DOUBLE_MS      window (ms) after a short release for a double-click, >= 1
//
// Ports
//   i_clk      system clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_debbtn   debounced button level, 1 = pressed, synchronous to i_clk
//   o_press    1-cycle pulse on each 0->1 edge
//   o_release  1-cycle pulse on each 1->0 edge
//   o_click    1-cycle pulse for a single short click
//   o_dclick   1-cycle pulse for a double-click
//   o_long     1-cycle pulse when a hold reaches LONG_MS
//   o_repeat   1-cycle pulse every REPEAT_MS while held after o_long
//   o_held     level, 1 while in PRESSED, SECOND or LONG_HELD
// -----------------------------------------------------------------------------
module button_event #(
  parameter int CLOCK_RATE_HZ = 16_000_000,
  parameter int LONG_MS       = 500,
  parameter int REPEAT_MS     = 100,
  parameter int DOUBLE_MS     = 250
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_debbtn,
  output logic o_press,
  output logic o_release,
  output logic o_click,
  output logic o_dclick,
  output logic o_long,
  output logic o_repeat,
  output logic o_held
);

  localparam int DIV = CLOCK_RATE_HZ / 1000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST  = PW'(DIV - 1);
  // A threshold of N ms is met on the tick that would move the counter
  // from N-1 to N, which places the pulse exactly N*DIV cycles after the
  // interval started.
  localparam logic [15:0]   LONG_LAST   = 16'(LONG_MS - 1);
  localparam logic [15:0]   REPEAT_LAST = 16'(REPEAT_MS - 1);
  localparam logic [15:0]   DOUBLE_LAST = 16'(DOUBLE_MS - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    WAIT2,
    SECOND,
    LONG_HELD
  } state_t;

  state_t        state;
  logic          prev;
  logic [PW-1:0] presc;
  logic [15:0]   ms_cnt;

  logic rise;
  logic fall;
  logic edge_seen;
  logic tick;
  logic hit_long;
  logic hit_repeat;
  logic hit_double;

  assign rise       = i_debbtn & ~prev;
  assign fall       = ~i_debbtn & prev;
  assign edge_seen  = rise | fall;
  assign tick       = (presc == PRESC_LAST);
  assign hit_long   = tick && (ms_cnt == LONG_LAST);
  assign hit_repeat = tick && (ms_cnt == REPEAT_LAST);
  assign hit_double = tick && (ms_cnt == DOUBLE_LAST);

  // NOTE: every register here, outputs included, is updated with <= so all
  // of them sample the same pre-edge values; later assignments in the block
  // override earlier defaults, which is how state entry re-clears the timebase.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: only real state is reset here; there are no memories in this
      // block, so every flop gets a defined value on reset.
      state     <= IDLE;
      prev      <= 1'b0;
      presc     <= '0;
      ms_cnt    <= '0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_click   <= 1'b0;
      o_dclick  <= 1'b0;
      o_long    <= 1'b0;
      o_repeat  <= 1'b0;
      o_held    <= 1'b0;
    end else begin
      prev      <= i_debbtn;
      o_press   <= rise;
      o_release <= fall;
      o_click   <= 1'b0;
      o_dclick  <= 1'b0;
      o_long    <= 1'b0;
      o_repeat  <= 1'b0;

      // Timebase: restart on any edge, otherwise count ms with saturation
      // so a very long idle never wraps back onto a threshold.
      if (edge_seen) begin
        presc  <= '0;
        ms_cnt <= '0;
      end else if (tick) begin
        presc <= '0;
        if (ms_cnt != 16'hFFFF) begin
          ms_cnt <= ms_cnt + 16'd1;
        end
      end else begin
        presc <= presc + 1'b1;
      end

      // Edges are tested before thresholds so an edge on the same cycle as
      // a threshold wins. Entries caused by edges are already covered by the
      // timebase restart above; threshold-driven entries restart it here.
      case (state)
        IDLE: begin
          if (rise) begin
            state  <= PRESSED;
            o_held <= 1'b1;
          end
        end

        PRESSED: begin
          if (fall) begin
            state  <= WAIT2;
            o_held <= 1'b0;
          end else if (hit_long) begin
            state  <= LONG_HELD;
            o_long <= 1'b1;
            presc  <= '0;
            ms_cnt <= '0;
          end
        end

        WAIT2: begin
          if (rise) begin
            state  <= SECOND;
            o_held <= 1'b1;
          end else if (hit_double) begin
            state   <= IDLE;
            o_click <= 1'b1;
            presc   <= '0;
            ms_cnt  <= '0;
          end
        end

        SECOND: begin
          if (fall) begin
            state    <= IDLE;
            o_dclick <= 1'b1;
            o_held   <= 1'b0;
          end else if (hit_long) begin
            // The pending first click is dropped: a long press wins.
            state  <= LONG_HELD;
            o_long <= 1'b1;
            presc  <= '0;
            ms_cnt <= '0;
          end
        end

        LONG_HELD: begin
          if (fall) begin
            state  <= IDLE;
            o_held <= 1'b0;
          end else if (hit_repeat) begin
            // Each repeat opens the next REPEAT_MS interval.
            o_repeat <= 1'b1;
            presc    <= '0;
            ms_cnt   <= '0;
          end
        end

        default: begin
          state  <= IDLE;
          o_held <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event.sv
// -----------------------------------------------------------------------------
// tb_button_event
//
// Directed bench for button_event with DIV=10, LONG_MS=5, REPEAT_MS=2,
// DOUBLE_MS=3. Inputs change 1 time unit after a rising edge; a monitor
// samples the outputs on the falling edge and records the cycle number of
// every pulse. Expected cycle numbers are written relative to the cycle of
// the first o_press of each scenario.
// -----------------------------------------------------------------------------
module tb_button_event;

  localparam int CLK_HZ = 10_000;
  localparam int L_MS   = 5;
  localparam int R_MS   = 2;
  localparam int D_MS   = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic btn   = 1'b0;

  logic o_press, o_release, o_click, o_dclick, o_long, o_repeat, o_held;

  button_event #(
    .CLOCK_RATE_HZ (CLK_HZ),
    .LONG_MS       (L_MS),
    .REPEAT_MS     (R_MS),
    .DOUBLE_MS     (D_MS)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_debbtn  (btn),
    .o_press   (o_press),
    .o_release (o_release),
    .o_click   (o_click),
    .o_dclick  (o_dclick),
    .o_long    (o_long),
    .o_repeat  (o_repeat),
    .o_held    (o_held)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse recorder
  int n_press = 0, n_rel = 0, n_click = 0, n_dclick = 0, n_long = 0, n_rep = 0;
  int press_at = -1, rel_at = -1, click_at = -1, dclick_at = -1, long_at = -1;
  int rep_q[$];
  int viol = 0;

  always @(negedge clk) begin
    if (o_press)   begin n_press++;  press_at  = cyc; end
    if (o_release) begin n_rel++;    rel_at    = cyc; end
    if (o_click)   begin n_click++;  click_at  = cyc; end
    if (o_dclick)  begin n_dclick++; dclick_at = cyc; end
    if (o_long)    begin n_long++;   long_at   = cyc; end
    if (o_repeat)  begin n_rep++;    rep_q.push_back(cyc); end
    if (o_press && o_release) viol++;
    if ($countones({o_click, o_dclick, o_long, o_repeat}) > 1) viol++;
  end

  int n_pass = 0, n_total = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int rep_at(input int idx);
    return (rep_q.size() > idx) ? rep_q[idx] : -1;
  endfunction

  int p, p2, c;
  int b_press, b_click, b_dclick, b_long, b_rep;

  task automatic snap();
    b_press  = n_press;
    b_click  = n_click;
    b_dclick = n_dclick;
    b_long   = n_long;
    b_rep    = n_rep;
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    btn   = 1'b0;
    run(3);
    check("rst_outputs", {25'd0, o_press, o_release, o_click, o_dclick,
                          o_long, o_repeat, o_held}, 0);
    rst_n = 1'b1;
    run(5);
    check("idle_quiet", n_press + n_rel, 0);

    // 1. Single click: high 20, low 60
    snap();
    p = cyc + 1;
    btn = 1'b1; run(10);
    check("s1_held", o_held, 1);
    run(10);
    btn = 1'b0; run(60);
    check("s1_press_at", press_at, p);
    check("s1_rel_at",   rel_at,   p + 20);
    check("s1_click_at", click_at, p + 50);
    check("s1_click_n",  n_click - b_click, 1);
    check("s1_no_long",  n_long - b_long, 0);
    check("s1_no_dclk",  n_dclick - b_dclick, 0);
    check("s1_held_off", o_held, 0);

    // 2. Double-click: high 10, low 15, high 10, low
    snap();
    p = cyc + 1;
    btn = 1'b1; run(10);
    btn = 1'b0; run(15);
    btn = 1'b1; run(10);
    btn = 1'b0; run(60);
    check("s2_press_n",  n_press - b_press, 2);
    check("s2_press2",   press_at, p + 25);
    check("s2_dclk_at",  dclick_at, p + 35);
    check("s2_rel_at",   rel_at, p + 35);
    check("s2_dclk_n",   n_dclick - b_dclick, 1);
    check("s2_no_click", n_click - b_click, 0);
    check("s2_no_long",  n_long - b_long, 0);

    // 3. Long press with auto-repeat: high 120
    snap();
    p = cyc + 1;
    btn = 1'b1; run(60);
    check("s3_held", o_held, 1);
    run(60);
    btn = 1'b0; run(40);
    check("s3_long_at",  long_at, p + 50);
    check("s3_long_n",   n_long - b_long, 1);
    check("s3_rep_n",    n_rep - b_rep, 3);
    check("s3_rep0",     rep_at(b_rep),     p + 70);
    check("s3_rep1",     rep_at(b_rep + 1), p + 90);
    check("s3_rep2",     rep_at(b_rep + 2), p + 110);
    check("s3_rel_at",   rel_at, p + 120);
    check("s3_no_click", n_click - b_click, 0);
    check("s3_no_dclk",  n_dclick - b_dclick, 0);

    // 4a. Release exactly at LONG_MS counts as short
    snap();
    p = cyc + 1;
    btn = 1'b1; run(50);
    btn = 1'b0; run(60);
    check("s4a_no_long",  n_long - b_long, 0);
    check("s4a_rel_at",   rel_at, p + 50);
    check("s4a_click_at", click_at, p + 80);
    check("s4a_click_n",  n_click - b_click, 1);

    // 4b. Second press exactly at DOUBLE_MS counts as double
    snap();
    p = cyc + 1;
    btn = 1'b1; run(10);
    btn = 1'b0; run(30);
    btn = 1'b1; run(10);
    btn = 1'b0; run(60);
    check("s4b_press2",   press_at, p + 40);
    check("s4b_no_click", n_click - b_click, 0);
    check("s4b_dclk_n",   n_dclick - b_dclick, 1);
    check("s4b_dclk_at",  dclick_at, p + 50);

    // 5. Reset during LONG_HELD, released with the button still high
    snap();
    p = cyc + 1;
    btn = 1'b1; run(65);
    check("s5_long_at",   long_at, p + 50);
    check("s5_held_pre",  o_held, 1);
    rst_n = 1'b0;
    #2;
    check("s5_async_clr", {25'd0, o_press, o_release, o_click, o_dclick,
                           o_long, o_repeat, o_held}, 0);
    run(3);
    rst_n = 1'b1;
    c  = cyc;
    p2 = c + 1;
    run(55);
    check("s5_press_at",  press_at, p2);
    check("s5_press_n",   n_press - b_press, 2);
    check("s5_long2_at",  long_at, p2 + 50);
    check("s5_no_rep",    n_rep - b_rep, 0);
    btn = 1'b0; run(40);
    check("s5_rel_at",    rel_at, p2 + 55);
    check("s5_no_click",  n_click - b_click, 0);

    // 6. Short click then second press held 60 cycles
    snap();
    p = cyc + 1;
    btn = 1'b1; run(5);
    check("s6_held1", o_held, 1);
    run(5);
    btn = 1'b0; run(5);
    check("s6_gap_held", o_held, 0);
    run(5);
    btn = 1'b1; run(30);
    check("s6_held2", o_held, 1);
    run(30);
    btn = 1'b0; run(60);
    check("s6_long_at",   long_at, p + 70);
    check("s6_rel_at",    rel_at, p + 80);
    check("s6_no_click",  n_click - b_click, 0);
    check("s6_no_dclk",   n_dclick - b_dclick, 0);
    check("s6_no_rep",    n_rep - b_rep, 0);

    // Exclusivity held across the whole run
    check("exclusive", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
